// File: rtl/uart_receiver_pkg.sv
// uart_receiver_pkg: frame defaults and state encoding shared by the UART receiver and transmitter.
package uart_receiver_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

endpackage

// File: rtl/sipo.sv
// sipo: serial-in parallel-out shift register, LSB received first (counterpart of the transmitter's piso).
module sipo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             serial_in,
    output logic [WIDTH-1:0] parallel_out
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    // New bits enter at the MSB so the first bit received ends up in bit 0.
    assign shreg_d      = shift ? {serial_in, shreg_q[WIDTH-1:1]} : shreg_q;
    assign parallel_out = shreg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) shreg_q <= '0;
        else     shreg_q <= shreg_d;
    end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: oversampled UART receiver with optional parity, frame/parity error flags and break handling.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                  rx_clk,
    input  logic                  rst,
    input  logic                  sample_tick,
    input  logic                  serial_in,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    uart_state_e           state_q, state_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [1:0]            sync_q;
    logic                  par_en_q, par_en_d;
    logic                  par_odd_q, par_odd_d;
    logic                  perr_int_q, perr_int_d;
    logic                  armed_q, armed_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  shift;
    logic                  rx_s;
    logic [DATA_WIDTH-1:0] shreg;

    assign rx_s = sync_q[1];

    sipo #(.WIDTH(DATA_WIDTH)) u_sipo (
        .clk          (rx_clk),
        .rst          (rst),
        .shift        (shift),
        .serial_in    (rx_s),
        .parallel_out (shreg)
    );

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        perr_int_d = perr_int_q;
        armed_d    = armed_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        shift      = 1'b0;
        if (sample_tick) begin
            tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
            case (state_q)
                ST_IDLE: begin
                    tick_d = '0;
                    // Only a high line re-arms detection, so a held-low break is one frame.
                    if (rx_s) armed_d = 1'b1;
                    else if (armed_q) begin
                        state_d    = ST_START;
                        par_en_d   = parity_en;
                        par_odd_d  = parity_odd;
                        perr_int_d = 1'b0;
                    end
                end
                ST_START: begin
                    if (tick_q == TICK_HALF) begin
                        state_d = rx_s ? ST_IDLE : ST_DATA;
                        tick_d  = '0;
                        bit_d   = '0;
                    end
                end
                ST_DATA: begin
                    if (tick_q == TICK_LAST) begin
                        shift = 1'b1;
                        bit_d = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (tick_q == TICK_LAST) begin
                        perr_int_d = rx_s != ((^shreg) ^ par_odd_q);
                        state_d    = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick_q == TICK_LAST) begin
                        valid_d = 1'b1;
                        data_d  = shreg;
                        perr_d  = perr_int_q;
                        ferr_d  = ~rx_s;
                        armed_d = rx_s;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            sync_q     <= 2'b11;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            perr_int_q <= 1'b0;
            armed_q    <= 1'b1;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            sync_q     <= {sync_q[0], serial_in};
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            perr_int_q <= perr_int_d;
            armed_q    <= armed_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = state_q != ST_IDLE;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames driven at 16 ticks per bit; a scoreboard checks every data_valid pulse.
`timescale 1ns/1ps
module tb_uart_receiver;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       serial_in = 1'b1;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   pulses = 0;

    uart_receiver dut (
        .rx_clk      (clk),
        .rst         (rst),
        .sample_tick (tick),
        .serial_in   (serial_in),
        .parity_en   (parity_en),
        .parity_odd  (parity_odd),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (tick !== 1'b1) @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // flip changes the parity inputs after the start bit to prove they are latched per frame
    task automatic send(input logic [7:0] d, input logic use_par, input logic par_bit,
                        input logic stop_bit, input logic flip);
        serial_in = 1'b0;
        ticks(16);
        if (flip) begin
            parity_en  = 1'b0;
            parity_odd = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            serial_in = d[i];
            ticks(16);
        end
        if (use_par) begin
            serial_in = par_bit;
            ticks(16);
        end
        serial_in = stop_bit;
        ticks(16);
        serial_in = 1'b1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (data_valid === 1'b1) begin
                pulses++;
                checks++;
                assert (sb.size() > 0) else begin
                    errors++;
                    $error("FAIL pulse: unexpected data_valid got data %h expected no pulse", data_out);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("data_out", data_out, e.data);
                    check("parity_err", {7'b0, parity_err}, {7'b0, e.perr});
                    check("frame_err", {7'b0, frame_err}, {7'b0, e.ferr});
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst data_out", data_out, 8'h00);
        check("rst data_valid", {7'b0, data_valid}, 8'h00);
        check("rst parity_err", {7'b0, parity_err}, 8'h00);
        check("rst frame_err", {7'b0, frame_err}, 8'h00);
        check("rst busy", {7'b0, busy}, 8'h00);
        rst = 1'b0;
        ticks(20);

        sb.push_back({8'hA5, 1'b0, 1'b0});
        send(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(40);
        check("hold data_out", data_out, 8'hA5);
        check("idle busy", {7'b0, busy}, 8'h00);

        serial_in = 1'b0;
        ticks(2);
        check("glitch busy", {7'b0, busy}, 8'h01);
        ticks(2);
        serial_in = 1'b1;
        ticks(8);
        check("false start busy", {7'b0, busy}, 8'h00);
        check("false start pulses", 8'(pulses), 8'd1);
        ticks(20);

        parity_en  = 1'b1;
        parity_odd = 1'b1;
        sb.push_back({8'h07, 1'b0, 1'b0});
        send(8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
        ticks(20);

        parity_en  = 1'b1;
        parity_odd = 1'b0;
        sb.push_back({8'h07, 1'b1, 1'b0});
        send(8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
        ticks(20);
        parity_en = 1'b0;

        sb.push_back({8'h3C, 1'b0, 1'b1});
        send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        serial_in = 1'b0;
        ticks(3 * 10 * 16);
        check("break pulses", 8'(pulses), 8'd4);
        check("break busy", {7'b0, busy}, 8'h00);
        serial_in = 1'b1;
        ticks(40);

        sb.push_back({8'h00, 1'b0, 1'b0});
        sb.push_back({8'hFF, 1'b0, 1'b0});
        send(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        send(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(20);
        check("b2b pulses", 8'(pulses), 8'd6);

        serial_in = 1'b0;
        ticks(16);
        for (int i = 0; i < 4; i++) begin
            serial_in = 1'(8'h5A >> i);
            ticks(16);
        end
        serial_in = 1'b1;
        ticks(8);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid rst busy", {7'b0, busy}, 8'h00);
        check("mid rst data_out", data_out, 8'h00);
        check("mid rst data_valid", {7'b0, data_valid}, 8'h00);
        rst = 1'b0;
        ticks(40);
        check("abort pulses", 8'(pulses), 8'd6);

        sb.push_back({8'h81, 1'b0, 1'b0});
        send(8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(40);
        check("final pulses", 8'(pulses), 8'd7);
        check("scoreboard empty", 8'(sb.size()), 8'd0);
        check("final data_out", data_out, 8'h81);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH from uart_params.vh (8), data bits per frame.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, sample_tick pulses per bit period; even, >= 4.
REQ-003 SHALL have port rx_clk  input  1  sole clock; all state updates on its posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sample_tick  input  1  one-cycle enable at OVERSAMPLE x baud rate.
REQ-006 SHALL have port serial_in  input  1  asynchronous UART line, idle high.
REQ-007 SHALL have port parity_en  input  1  1 = frame carries a parity bit after the data bits.
REQ-008 SHALL have port parity_odd  input  1  1 = odd parity, 0 = even parity; ignored when parity_en = 0.
REQ-009 SHALL have port data_out  output  DATA_WIDTH  last received word, LSB received first.
REQ-010 SHALL have port data_valid  output  1  one-cycle pulse when a frame completes.
REQ-011 SHALL have port parity_err  output  1  parity mismatch flag for the frame of the current data_valid.
REQ-012 SHALL have port frame_err  output  1  stop bit sampled low for the frame of the current data_valid.
REQ-013 SHALL have port busy  output  1  high in every state other than IDLE.

Function
REQ-014 SHALL pass serial_in through a 2-flop synchronizer (reset value 1); all sampling uses the synchronized bit rx_s.
REQ-015 SHALL implement the states IDLE, START, DATA, PARITY and STOP, with a tick counter of width clog2(OVERSAMPLE) and a bit counter of width clog2(DATA_WIDTH).
REQ-016 IDLE: on a sample_tick with rx_s = 0, SHALL go to START, clear the tick counter and set busy.
REQ-017 START: on the tick where the counter reaches OVERSAMPLE/2-1, SHALL sample rx_s: 0 -> DATA with counters cleared; 1 -> false start, back to IDLE with no flags raised.
REQ-018 DATA: every OVERSAMPLE ticks, SHALL shift rx_s into a shift register, LSB first; after DATA_WIDTH samples, SHALL go to PARITY if parity_en = 1, else to STOP.
REQ-019 PARITY: after OVERSAMPLE ticks, SHALL sample rx_s and compare it against XOR(data) ^ parity_odd; a mismatch sets an internal parity error.
REQ-020 STOP: after OVERSAMPLE ticks, SHALL sample rx_s; a 0 sets frame_err; on that same edge SHALL load data_out, set data_valid = 1 and update parity_err, then go to IDLE.
REQ-021 data_valid SHALL be high for exactly one rx_clk cycle per completed frame, including frames with errors.
REQ-022 data_out, parity_err and frame_err SHALL hold their values until the next completed frame.
REQ-023 Counters SHALL advance only on sample_tick; with no tick the state is frozen.
REQ-024 parity_en and parity_odd SHALL be sampled once, on the IDLE->START transition, and held for the whole frame.
REQ-025 After a frame_err, IDLE SHALL re-arm only once rx_s = 1 has been seen on a tick, so a break condition (line held low) yields one frame, not a stream of frames.
REQ-026 Latency from the stop-bit mid-sample tick to data_valid SHALL be 1 rx_clk cycle.

Reset
REQ-027 Asserting rst SHALL immediately force state = IDLE, counters = 0, shift register = 0, data_out = 0, data_valid = 0, parity_err = 0, frame_err = 0, busy = 0 and synchronizer flops = 1.
REQ-028 Asserting rst mid-frame SHALL abort the frame with no data_valid; reception resumes on the first start edge after rst deasserts.

Structure
REQ-029 DATA_WIDTH and OVERSAMPLE defaults, and the state encodings, SHALL be defined in uart_params.vh and shared with the transmitter.
REQ-030 The data shift register SHALL be a separate sub-module, sipo (inputs shift, serial_in; output parallel_out), mirroring the transmitter's piso.

Verification
REQ-031 Frame 0xA5, no parity, 16x ticks -> data_valid one cycle, data_out = 0xA5, parity_err = 0, frame_err = 0.
REQ-032 Low glitch on serial_in lasting 4 ticks -> false start, no data_valid, busy back to 0 within 8 ticks.
REQ-033 parity_en = 1, even, data 0x07 sent with parity bit 0 -> data_out = 0x07, parity_err = 1.
REQ-034 Data 0x3C with stop bit 0, then line held low for 3 frame times -> exactly one data_valid with frame_err = 1, none after.
REQ-035 Back-to-back frames 0x00 then 0xFF with no idle gap -> two data_valid pulses carrying 0x00 then 0xFF, no errors.
REQ-036 rst asserted during data bit 4 of 0x5A, then frame 0x81 -> no pulse for the aborted frame; data_out = 0x81.
